// File: rtl/fir_mac_filter_if.sv
// Sample/coefficient strobe and filtered-output bundle for fir_mac_filter.
// master drives samples and coefficients; slave is the filter itself.
interface fir_mac_filter_if #(
    parameter int DATA_W  = 8,
    parameter int COEFF_W = 8,
    parameter int OUT_W   = 14
);
    logic signed [DATA_W-1:0]  x_in;
    logic                      in_valid;
    logic                      in_ready;
    logic                      coef_load;
    logic signed [COEFF_W-1:0] coef_in;
    logic signed [OUT_W-1:0]   y_out;
    logic                      out_valid;

    modport master (
        output x_in, in_valid, coef_load, coef_in,
        input  in_ready, y_out, out_valid
    );

    modport slave (
        input  x_in, in_valid, coef_load, coef_in,
        output in_ready, y_out, out_valid
    );
endinterface

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one shared signed MAC, one tap per clock, run-time coefficient shift-in.
// Define FIR_SATURATE_EN to clamp the narrowed output instead of two's-complement wrapping.
module fir_mac_filter #(
    parameter int TAPS      = 8,
    parameter int DATA_W    = 8,
    parameter int COEFF_W   = 8,
    parameter int OUT_W     = 14,
    parameter int OUT_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_mac_filter_if.slave  bus
);
    localparam int ACC_W  = DATA_W + COEFF_W + $clog2(TAPS);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int EXT_W  = ACC_W + OUT_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    logic [1:0]                r_state;
    logic signed [DATA_W-1:0]  r_d [TAPS];
    logic signed [COEFF_W-1:0] r_h [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]          r_idx;
    logic signed [OUT_W-1:0]   r_y_out;
    logic                      r_out_valid;
    logic                      r_in_ready;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [EXT_W-1:0]   w_shifted;
    logic signed [OUT_W-1:0]   w_y_next;

    assign w_prod     = r_h[r_idx] * r_d[r_idx];
    assign w_acc_next = r_acc + ACC_W'(w_prod);
    // Widen before shifting so the selected window never runs past the accumulator MSB.
    assign w_shifted  = EXT_W'(w_acc_next) >>> OUT_SHIFT;

`ifdef FIR_SATURATE_EN
    localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        w_y_next = OUT_W'(w_shifted);
        if (w_shifted > OUT_MAX) begin
            w_y_next = OUT_W'(OUT_MAX);
        end else if (w_shifted < OUT_MIN) begin
            w_y_next = OUT_W'(OUT_MIN);
        end
    end
`else
    assign w_y_next = OUT_W'(w_shifted);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_y_out     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            // NOTE: delay line and coefficient bank are flops, not RAM, so reset clears them
            // and restores the impulse bank (passthrough filter).
            for (int k = 0; k < TAPS; k++) begin
                r_d[k] <= '0;
                r_h[k] <= (k == 0) ? COEFF_W'(1) : '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        if (bus.coef_load) begin
                            for (int k = 0; k < TAPS - 1; k++) begin
                                r_h[k] <= r_h[k+1];
                            end
                            r_h[TAPS-1] <= bus.coef_in;
                        end else begin
                            r_d[0] <= bus.x_in;
                            for (int k = 1; k < TAPS; k++) begin
                                r_d[k] <= r_d[k-1];
                            end
                            r_acc      <= '0;
                            r_idx      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_y_out     <= w_y_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.y_out     = r_y_out;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter at default parameters; expectations follow FIR_SATURATE_EN.
module tb_fir_mac_filter;
    localparam int TAPS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fir_mac_filter_if #(.DATA_W(8), .COEFF_W(8), .OUT_W(14)) bus ();

    fir_mac_filter #(.TAPS(TAPS), .DATA_W(8), .COEFF_W(8), .OUT_W(14), .OUT_SHIFT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.coef_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst y_out", int'(bus.y_out), 0);
        check("rst out_valid", int'(bus.out_valid), 0);
        check("rst in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic load_coef(input int c);
        @(negedge clk);
        bus.coef_in   = 8'(c);
        bus.coef_load = 1'b1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.coef_load = 1'b0;
    endtask

    // Strobe one sample and wait (bounded) for its output pulse.
    task automatic send_sample(input string tag, input int x, input bit chk_y, input int exp_y);
        int cycles;
        @(negedge clk);
        check({tag, " ready"}, int'(bus.in_ready), 1);
        bus.x_in     = 8'(x);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cycles = 2;
        while (!bus.out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, cycles, TAPS + 2);
        if (chk_y) check({tag, " y_out"}, int'(bus.y_out), exp_y);
        @(negedge clk);
        check({tag, " pulse width"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int low_cnt;
        int pulse_cnt;
        int y_seen;
        bus.x_in      = '0;
        bus.in_valid  = 1'b0;
        bus.coef_load = 1'b0;
        bus.coef_in   = '0;

        // Passthrough after reset.
        do_reset();
        send_sample("pass5", 5, 1'b1, 5);
        send_sample("pass-3", -3, 1'b1, -3);

        // Output narrowing: all taps 127.
        do_reset();
        for (int i = 0; i < TAPS; i++) load_coef(127);
        for (int i = 0; i < TAPS - 1; i++) send_sample("fill127", 127, 1'b0, 0);
`ifdef FIR_SATURATE_EN
        send_sample("max127", 127, 1'b1, 8191);
`else
        send_sample("max127", 127, 1'b1, -2040);
`endif
        for (int i = 0; i < TAPS - 1; i++) send_sample("fill-128", -128, 1'b0, 0);
`ifdef FIR_SATURATE_EN
        send_sample("min-128", -128, 1'b1, -8192);
`else
        send_sample("min-128", -128, 1'b1, 1024);
`endif

        // Impulse through coefficients 1,2,3,4,0,0,0,0.
        do_reset();
        load_coef(1); load_coef(2); load_coef(3); load_coef(4);
        for (int i = 0; i < 4; i++) load_coef(0);
        send_sample("imp0", 1, 1'b1, 1);
        send_sample("imp1", 0, 1'b1, 2);
        send_sample("imp2", 0, 1'b1, 3);
        send_sample("imp3", 0, 1'b1, 4);
        send_sample("imp4", 0, 1'b1, 0);

        // Strobes during MAC are dropped.
        do_reset();
        @(negedge clk);
        bus.x_in     = 8'sd6;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.x_in = 8'sd50;
        low_cnt   = 0;
        pulse_cnt = 0;
        y_seen    = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) bus.in_valid = 1'b0;
            if (!bus.in_ready) low_cnt++;
            if (bus.out_valid) begin
                pulse_cnt++;
                y_seen = int'(bus.y_out);
            end
            @(negedge clk);
        end
        check("drop ready-low cycles", low_cnt, 9);
        check("drop pulses", pulse_cnt, 1);
        check("drop y_out", y_seen, 6);

        // Coefficient strobe leaves the delay line alone and shifts the bank.
        do_reset();
        send_sample("dl0", 3, 1'b1, 3);
        for (int i = 1; i < TAPS - 1; i++) send_sample("dl", 10 + i, 1'b1, 10 + i);
        load_coef(5);
        pulse_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) pulse_cnt++;
            @(negedge clk);
        end
        check("coef strobe pulses", pulse_cnt, 0);
        send_sample("shifted bank", 17, 1'b1, 15);

        // Reset in the middle of a computation.
        do_reset();
        load_coef(3);
        for (int i = 0; i < TAPS - 1; i++) load_coef(0);
        send_sample("h0=3", 2, 1'b1, 6);
        @(negedge clk);
        bus.x_in     = 8'sd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) pulse_cnt++;
            @(negedge clk);
        end
        check("midrst pulses", pulse_cnt, 0);
        check("midrst y_out", int'(bus.y_out), 0);
        send_sample("after midrst", 7, 1'b1, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised, time-multiplexed FIR filter: the successor to the fixed 8-bit-in/14-bit-out tile FIR. Tap count, data, coefficient and output widths are generics. One shared signed multiplier-accumulator runs one tap per clock. Coefficients load at run time through a shift-in port, and the output is valid-qualified. It sits between the tile pin mapping (`ui_in`/`uio_in` → samples/strobes) and the output pins (`uo_out`/`uio_out`).

## Interface
Parameters:
- `TAPS`, 8, number of filter taps (≥2)
- `DATA_W`, 8, signed input sample width
- `COEFF_W`, 8, signed coefficient width
- `OUT_W`, 14, signed output width
- `OUT_SHIFT`, 0, accumulator LSBs discarded before output selection
- Derived: `ACC_W` = DATA_W+COEFF_W+$clog2(TAPS)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `x_in`  in  DATA_W  signed sample
- `in_valid`  in  1  sample/coefficient strobe
- `in_ready`  out  1  high when block accepts a strobe
- `coef_load`  in  1  qualifies strobe as coefficient write
- `coef_in`  in  COEFF_W  signed coefficient
- `y_out`  out  OUT_W  signed filtered output, held between updates
- `out_valid`  out  1  one-cycle pulse, `y_out` updated this cycle

## Operation
- Storage: delay line `d[0..TAPS-1]` (`d[0]` newest), coefficient bank `h[0..TAPS-1]`, accumulator `ACC_W` bits, tap index counter `$clog2(TAPS)` bits.
- FSM states: IDLE, MAC, DONE.
- IDLE: `in_ready`=1.
  - `in_valid & coef_load`: coefficient shift. Each `h[k]` takes `h[k+1]`, and `h[TAPS-1]` takes `coef_in`. After TAPS writes, the first value written sits in `h[0]`. Stay in IDLE.
  - `in_valid & !coef_load`: delay line shifts (`d[0]`←`x_in`, `d[k]`←`d[k-1]`), acc←0, idx←0, go to MAC.
  - `coef_load` has priority, so a simultaneous strobe never enters a sample.
- MAC: `in_ready`=0, and strobes are ignored (not queued). Each cycle does acc += `h[idx]`·`d[idx]`, full-precision signed, sign-extended to ACC_W, then idx++. After idx=TAPS-1 is accumulated, go to DONE.
- DONE: `y_out` ← acc[OUT_SHIFT+OUT_W-1 : OUT_SHIFT] (see Configuration), `out_valid`=1, `in_ready`=0, go to IDLE.
- ACC_W guarantees the accumulator itself never overflows. Only output narrowing can overflow.

## Timing
- Reset values: `y_out`=0, `out_valid`=0, `in_ready`=0 during the reset cycle and 1 from the first cycle after `rst_n` is high. `d[*]`=0, acc=0, idx=0, FSM=IDLE. Coefficients reset to impulse, `h[0]`=1 and others 0, so the block is passthrough after reset.
- Sample accepted at edge T0. MAC occupies T0+1..T0+TAPS. `out_valid` is high in cycle T0+TAPS+1.
- Throughput is one sample per TAPS+2 cycles. `in_ready` returns high the cycle after `out_valid`.
- A coefficient write takes effect for the next accepted sample.
- Reset asserted during MAC/DONE: computation is discarded, no `out_valid`, and all state returns to reset values, including coefficients.
- `in_valid` while `in_ready`=0: dropped, no state change.

## Configuration
- `FIR_SATURATE_EN` defined: if the accumulator, arithmetically shifted right by OUT_SHIFT, exceeds the signed OUT_W range, `y_out` clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Not defined: plain bit-slice truncation with two's-complement wrap, no compare logic.

## Test plan
- Reset then `x_in`=5 strobe, default params → `out_valid` exactly 10 cycles after acceptance, `y_out`=5. `x_in`=-3 → `y_out`=-3.
- Load coefficients 1,2,3,4,0,0,0,0, then feed samples 1,0,0,0,0 → successive `y_out` 1,2,3,4,0.
- All coefficients 127, eight samples of 127 (acc 129032) → with `FIR_SATURATE_EN` `y_out`=8191. Without it `y_out`=-2040. All coefficients 127, samples -128 → saturated `y_out`=-8192.
- Strobe a sample, and strobe `in_valid` again during MAC → second strobe dropped, only one `out_valid`, `in_ready` low for exactly 9 cycles of the 10-cycle computation.
- `in_valid` with `coef_load`=1 in IDLE → no `out_valid`, delay line unchanged. Next sample output uses the shifted coefficient bank.
- `rst_n` low for one cycle mid-MAC → no `out_valid`, `y_out`=0, coefficients back to impulse, and the next sample 7 → `y_out`=7.
